// File: rtl/pmem_pkg.sv
// Shared types and parameter helpers for the pmem line responder.
package pmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} pmem_state_t;

    function automatic int pmem_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int pmem_beats(input int line_bits, input int word_bits);
        return line_bits / word_bits;
    endfunction

    function automatic int pmem_idx_bits(input int depth_lines);
        return pmem_clog2_min1(depth_lines);
    endfunction

    function automatic bit pmem_cfg_ok(input int line_bits, input int word_bits,
                                       input int depth_lines, input int latency);
        return (word_bits > 0) && (line_bits >= word_bits) && (line_bits % word_bits == 0)
            && (depth_lines >= 2) && ((depth_lines & (depth_lines - 1)) == 0)
            && (latency >= 0);
    endfunction

endpackage

// File: rtl/pmem_array.sv
// Word-wide backing store: synchronous write, combinational read, contents not reset.
module pmem_array
    import pmem_pkg::*;
#(
    parameter int WORDS     = 4096,
    parameter int WORD_BITS = 32,
    parameter int AW        = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pmem_responder.sv
// Main-memory line responder: serializes one cache line per request over BEATS words.
// Optional PMEM_PROTO_CHECK_EN adds a sticky protocol-violation flag on `error`.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LINE_BITS   = 256,
    parameter int WORD_BITS   = 32,
    parameter int ADDR_BITS   = 32,
    parameter int DEPTH_LINES = 512,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [ADDR_BITS-1:0] mem_addr,
    input  logic [LINE_BITS-1:0] mem_wdata,
    output logic [LINE_BITS-1:0] mem_rdata,
    output logic                 mem_resp,
    output logic                 busy,
    output logic                 error
);

    localparam int BEATS    = pmem_beats(LINE_BITS, WORD_BITS);
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS = pmem_idx_bits(DEPTH_LINES);
    localparam int BW       = pmem_clog2_min1(BEATS);
    localparam int AW       = pmem_clog2_min1(DEPTH_LINES * BEATS);
    localparam int LW       = pmem_clog2_min1(LATENCY + 1);

    if (!pmem_cfg_ok(LINE_BITS, WORD_BITS, DEPTH_LINES, LATENCY)) begin : g_bad_cfg
        $error("pmem_responder: invalid LINE_BITS/WORD_BITS/DEPTH_LINES/LATENCY");
    end

    pmem_state_t state_q, state_d;

    logic                             armed_q;
    logic                             op_wr_q;
    logic [IDX_BITS-1:0]              idx_q;
    logic [BEATS-1:0][WORD_BITS-1:0]  wdata_buf;
    logic [BEATS-1:0][WORD_BITS-1:0]  rdata_buf;
    logic [LW-1:0]                    wait_cnt;
    logic [BW-1:0]                    beat_cnt;

    logic                 req, accept, wait_done, last_beat;
    logic                 arr_we;
    logic [AW-1:0]        arr_addr;
    logic [WORD_BITS-1:0] arr_rdata;

    // A request held across RESP must drop before it can be accepted again.
    assign req       = mem_read | mem_write;
    assign accept    = (state_q == IDLE) && req && armed_q;
    assign wait_done = (wait_cnt == '0);
    assign last_beat = (beat_cnt == BW'(BEATS - 1));
    assign arr_addr  = AW'(idx_q) * AW'(BEATS) + AW'(beat_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (LATENCY == 0) ? XFER : WAIT;
            WAIT:    if (wait_done) state_d = XFER;
            XFER:    if (last_beat) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_resp = (state_q == RESP);
        busy     = (state_q != IDLE);
        arr_we   = (state_q == XFER) && op_wr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q   <= 1'b1;
            op_wr_q   <= 1'b0;
            idx_q     <= '0;
            wdata_buf <= '0;
            rdata_buf <= '0;
            wait_cnt  <= '0;
            beat_cnt  <= '0;
        end else begin
            if (!req)        armed_q <= 1'b1;
            else if (accept) armed_q <= 1'b0;

            if (accept) begin
                op_wr_q   <= mem_write;
                idx_q     <= mem_addr[OFF_BITS +: IDX_BITS];
                wdata_buf <= mem_wdata;
                wait_cnt  <= LW'(LATENCY - 1);
            end

            if (state_q == WAIT && !wait_done) wait_cnt <= wait_cnt - 1'b1;

            if (state_q == XFER) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                if (!op_wr_q) rdata_buf[beat_cnt] <= arr_rdata;
            end
        end
    end

    assign mem_rdata = rdata_buf;

    pmem_array #(
        .WORDS     (DEPTH_LINES * BEATS),
        .WORD_BITS (WORD_BITS),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_buf[beat_cnt]),
        .rdata (arr_rdata)
    );

`ifdef PMEM_PROTO_CHECK_EN
    logic                 err_q;
    logic [ADDR_BITS-1:0] addr_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            addr_prev <= '0;
        end else begin
            addr_prev <= mem_addr;
            if ((state_q == IDLE && mem_read && mem_write) ||
                (busy && mem_read && mem_addr != addr_prev))
                err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    logic unused_addr;
    assign unused_addr = ^mem_addr;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: default build plus a LATENCY=0 instance.
module tb_pmem_responder;

    typedef struct {
        bit           rd;
        logic [255:0] line;
        int           acc;
    } exp_t;

`ifdef PMEM_PROTO_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd    [2];
    logic         wr    [2];
    logic [31:0]  addr  [2];
    logic [255:0] wdata [2];
    logic [255:0] rdata [2];
    logic         resp  [2];
    logic         busy  [2];
    logic         error [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nresp  [2];

    exp_t         sbq0 [$];
    exp_t         sbq1 [$];
    logic [255:0] mdl0 [int];
    logic [255:0] mdl1 [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_responder u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
        .mem_resp(resp[0]), .busy(busy[0]), .error(error[0])
    );

    pmem_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
        .mem_resp(resp[1]), .busy(busy[1]), .error(error[1])
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request for `hold` cycles; the expected outcome is queued at drive time.
    task automatic do_req(input int d, input bit wrq, input bit rdq, input logic [31:0] a,
                          input logic [255:0] line, input int hold, output int acc);
        exp_t e;
        int   idx;
        @(posedge clk);
        #1;
        rd[d] = rdq; wr[d] = wrq; addr[d] = a; wdata[d] = line;
        idx   = int'((a >> 5) & 32'h1FF);
        acc   = cyc;
        e.rd  = !wrq;
        e.acc = cyc;
        e.line = '0;
        if (wrq) begin
            if (d == 0) mdl0[idx] = line; else mdl1[idx] = line;
        end else begin
            e.line = (d == 0) ? mdl0[idx] : mdl1[idx];
        end
        if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
        for (int i = 0; i < hold; i++) @(posedge clk);
        #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, output int nb);
        int n;
        nb = 0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (busy[d]) nb++;
            else if (nb > 0) break;
        end
        chk("idle_reached", 256'(n < 60), 256'd1);
    endtask

    task automatic rand_line(output logic [255:0] l);
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    endtask

    initial begin : mon
        exp_t e;
        bit   got;
        nresp[0] = 0;
        nresp[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n && resp[d]) begin
                    got = 1'b0;
                    if (d == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); got = 1'b1; end
                    else if (d == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); got = 1'b1; end
                    nresp[d]++;
                    chk($sformatf("resp_expected_d%0d", d), 256'(got), 256'd1);
                    if (got) begin
                        chk($sformatf("resp_latency_d%0d", d), 256'(cyc - e.acc),
                            256'((d == 0) ? 13 : 9));
                        if (e.rd) chk($sformatf("rdata_d%0d", d), rdata[d], e.line);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [255:0] w1, l, last;
        logic [31:0]  a;
        int           acc, nb, n0, idx;

        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_resp",  256'(resp[d]),  256'd0);
            chk("rst_busy",  256'(busy[d]),  256'd0);
            chk("rst_error", 256'(error[d]), 256'd0);
            chk("rst_rdata", rdata[d],       256'd0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) w1[k*32 +: 32] = 32'(32'h1111_1111 * (k + 1));

        // single-cycle write pulse, then read back
        do_req(0, 1'b1, 1'b0, 32'h1000, w1, 1, acc);
        wait_idle(0, nb);
        chk("wr_pulse_busy", 256'(nb), 256'd13);
        do_req(0, 1'b0, 1'b1, 32'h1000, '0, 1, acc);
        wait_idle(0, nb);
        chk("rd_busy", 256'(nb), 256'd13);

        // random lines written with junk offset/upper bits, read back via an alias address
        last = '0;
        for (int i = 0; i < 4; i++) begin
            idx = $urandom_range(200, 511);
            rand_line(l);
            a = ($urandom & 32'hFFFF_C000) | 32'(idx << 5) | 32'($urandom_range(0, 31));
            do_req(0, 1'b1, 1'b0, a, l, 1, acc);
            wait_idle(0, nb);
            a = ($urandom & 32'hFFFF_C000) | 32'(idx << 5);
            do_req(0, 1'b0, 1'b1, a, '0, 1, acc);
            wait_idle(0, nb);
            last = l;
        end

        // a write leaves the read buffer alone
        rand_line(l);
        do_req(0, 1'b1, 1'b0, 32'h0000_0020, l, 1, acc);
        wait_idle(0, nb);
        chk("rdata_hold_after_wr", rdata[0], last);

        // read held well past RESP: one response only, re-armed after drop
        n0 = nresp[0];
        do_req(0, 1'b0, 1'b1, 32'h1000, '0, 30, acc);
        repeat (3) @(negedge clk);
        chk("held_one_resp", 256'(nresp[0] - n0), 256'd1);
        chk("held_busy_low", 256'(busy[0]), 256'd0);
        do_req(0, 1'b0, 1'b1, 32'h1000, '0, 1, acc);
        wait_idle(0, nb);
        chk("rearm_resp", 256'(nresp[0] - n0), 256'd2);

        // read and write together: write wins
        rand_line(l);
        do_req(0, 1'b1, 1'b1, 32'h2040, l, 1, acc);
        wait_idle(0, nb);
        chk("both_busy", 256'(nb), 256'd13);
        chk("both_error", 256'(error[0]), 256'(EXP_ERR));
        do_req(0, 1'b0, 1'b1, 32'h2040, '0, 1, acc);
        wait_idle(0, nb);

        // reset during XFER beat 3 of a read
        do_req(0, 1'b0, 1'b1, 32'h1000, '0, 1, acc);
        n0 = nresp[0];
        for (int g = 0; g < 40 && cyc != acc + 8; g++) @(negedge clk);
        chk("rst_reach_beat3", 256'(cyc), 256'(acc + 8));
        rst_n = 1'b0;
        sbq0.delete();
        #1;
        chk("rst_mid_busy",  256'(busy[0]), 256'd0);
        chk("rst_mid_resp",  256'(resp[0]), 256'd0);
        chk("rst_mid_rdata", rdata[0],      256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_resp", 256'(nresp[0] - n0), 256'd0);
        chk("rst_busy_after", 256'(busy[0]), 256'd0);
        do_req(0, 1'b0, 1'b1, 32'h1000, '0, 1, acc);
        wait_idle(0, nb);
        chk("post_rst_busy", 256'(nb), 256'd13);

        // LATENCY=0 instance: 9-cycle turnaround, 0x4000 aliases to line 0
        rand_line(l);
        do_req(1, 1'b1, 1'b0, 32'h4000, l, 1, acc);
        wait_idle(1, nb);
        chk("lat0_busy", 256'(nb), 256'd9);
        do_req(1, 1'b0, 1'b1, 32'h0000, '0, 1, acc);
        wait_idle(1, nb);
        chk("lat0_alias_rdata", rdata[1], l);

        repeat (3) @(negedge clk);
        chk("sbq0_drained", 256'(sbq0.size()), 256'd0);
        chk("sbq1_drained", 256'(sbq1.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
